// File: rtl/mcast_tag_sender_if.sv
// -----------------------------------------------------------------------------
// mcast_tag_sender_if
//
// Purpose: bundles the two streaming handshakes of the multicast tag sender.
//    The input stream carries plain words from the global buffer. The output
//    stream carries tagged (value, tag) beats toward the multicast router.
//
// Signals:
//    in_data   - word from the global buffer
//    in_valid  - in_data valid
//    in_ready  - sender can accept; a word transfers when in_valid & in_ready
//    out_val   - value to the router
//    out_tag   - target ID for the value
//    out_valid - beat valid
//    out_ready - router accepts; a beat transfers when out_valid & out_ready
//
// Modports:
//    master - the sender (consumes the input stream, drives the output stream)
//    slave  - the environment around it (buffer side and router side)
// -----------------------------------------------------------------------------
interface mcast_tag_sender_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ID_WIDTH   = 4
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] out_val;
   logic [ID_WIDTH-1:0]   out_tag;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      input  in_data, in_valid, out_ready,
      output in_ready, out_val, out_tag, out_valid
   );

   modport slave (
      output in_data, in_valid, out_ready,
      input  in_ready, out_val, out_tag, out_valid
   );
endinterface

// File: rtl/mcast_tag_sender.sv
// -----------------------------------------------------------------------------
// mcast_tag_sender
//
// Purpose: transmit end of the tagged multicast bus feeding the PE array.
//    Words from the global buffer are queued in a small FIFO, then emitted one
//    per beat with a target tag drawn from a configured window of IDs. A pass
//    is started by cfg_start and emits cfg_words words; done pulses for one
//    cycle when the pass ends.
//
// Ports:
//    clk           - clock
//    rst           - asynchronous reset, active-low
//    bus           - mcast_tag_sender_if.master (input stream + tagged output)
//    cfg_start     - one-cycle pulse, starts a pass (ignored unless idle)
//    cfg_start_tag - first tag of the pass
//    cfg_num_tags  - tag window size (0 treated as 1, clamped to NUM_IDS)
//    cfg_words     - number of words to emit in the pass
//    cfg_bcast     - broadcast mode (only honoured with the macro below)
//    busy          - pass in progress
//    done          - one-cycle pulse at end of pass
//
// Build option:
//    MCAST_TAG_SENDER_BCAST_EN - when defined, a pass with cfg_bcast=1 sends
//    every word to each tag of the window in order before popping it. When
//    undefined, cfg_bcast is ignored.
// -----------------------------------------------------------------------------
module mcast_tag_sender #(
   parameter int DATA_WIDTH = 16,
   parameter int ID_WIDTH   = 4,
   parameter int NUM_IDS    = 14,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   mcast_tag_sender_if.master  bus,
   input  logic                cfg_start,
   input  logic [ID_WIDTH-1:0] cfg_start_tag,
   input  logic [ID_WIDTH:0]   cfg_num_tags,
   input  logic [15:0]         cfg_words,
   input  logic                cfg_bcast,
   output logic                busy,
   output logic                done
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   // Tag sum needs headroom for start_tag + index before the modulo fold.
   localparam int TW = ID_WIDTH + 2;
   localparam logic [ID_WIDTH:0] NUM_IDS_W = (ID_WIDTH + 1)'(NUM_IDS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIN
   } state_t;

   // ---------------------------------------------------------------- FIFO --
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]           wr_ptr_q, wr_ptr_d;
   logic [AW:0]           rd_ptr_q, rd_ptr_d;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] fifo_head;

   assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
   assign fifo_full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                         (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign bus.in_ready = !fifo_full;
   assign push         = bus.in_valid && !fifo_full;
   // Head comes from registered pointers only, so a word pushed into an empty
   // FIFO becomes visible the cycle after it is written (no bypass).
   assign fifo_head    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
      rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
      end
   end

   // ------------------------------------------------------- pass control --
   state_t                state_q, state_d;
   logic [ID_WIDTH-1:0]   start_tag_q, start_tag_d;
   logic [ID_WIDTH:0]     win_q, win_d;
   logic [15:0]           words_q, words_d;
   logic [15:0]           word_cnt_q, word_cnt_d;   // words whose last beat transferred
   logic [15:0]           load_cnt_q, load_cnt_d;   // words fully loaded into the slot
   logic [ID_WIDTH:0]     tag_idx_q, tag_idx_d;
   logic [DATA_WIDTH-1:0] out_val_q, out_val_d;
   logic [ID_WIDTH-1:0]   out_tag_q, out_tag_d;
   logic                  out_valid_q, out_valid_d;

   logic [ID_WIDTH:0]     win_clamped;
   logic [TW-1:0]         tag_sum;
   logic [ID_WIDTH-1:0]   cur_tag;
   logic                  last_idx;
   logic                  transfer;
   logic                  beat_last;
   logic                  load;
   logic                  word_loaded;
   logic                  final_beat;

`ifdef MCAST_TAG_SENDER_BCAST_EN
   logic                  bcast_q, bcast_d;
   logic                  out_last_q, out_last_d;  // slot holds the final replica of its word

   assign beat_last   = out_last_q;
   // In broadcast the word stays at the FIFO head until its final replica loads.
   assign word_loaded = load && (!bcast_q || last_idx);
`else
   logic                  unused_cfg_bcast;

   assign unused_cfg_bcast = cfg_bcast;
   assign beat_last        = 1'b1;
   assign word_loaded      = load;
`endif

   always_comb begin
      win_clamped = cfg_num_tags;
      if (cfg_num_tags == '0) begin
         win_clamped = (ID_WIDTH + 1)'(1);
      end else if (cfg_num_tags > NUM_IDS_W) begin
         win_clamped = NUM_IDS_W;
      end
   end

   always_comb begin
      tag_sum = TW'(start_tag_q) + TW'(tag_idx_q);
      if (tag_sum >= TW'(NUM_IDS)) begin
         tag_sum = tag_sum - TW'(NUM_IDS);
      end
      cur_tag = ID_WIDTH'(tag_sum);
   end

   assign last_idx   = ((tag_idx_q + (ID_WIDTH + 1)'(1)) == win_q);
   assign transfer   = out_valid_q && bus.out_ready;
   // Load into the slot when it is empty or being emptied this cycle, and
   // never past the configured word count so extra words stay queued.
   assign load       = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready) &&
                       !fifo_empty && (load_cnt_q != words_q);
   assign pop        = word_loaded;
   assign final_beat = transfer && beat_last && ((word_cnt_q + 16'd1) == words_q);

   always_comb begin
      state_d     = state_q;
      start_tag_d = start_tag_q;
      win_d       = win_q;
      words_d     = words_q;
      word_cnt_d  = word_cnt_q;
      load_cnt_d  = load_cnt_q;
      tag_idx_d   = tag_idx_q;
      out_val_d   = out_val_q;
      out_tag_d   = out_tag_q;
      out_valid_d = out_valid_q;
`ifdef MCAST_TAG_SENDER_BCAST_EN
      bcast_d     = bcast_q;
      out_last_d  = out_last_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               start_tag_d = cfg_start_tag;
               win_d       = win_clamped;
               words_d     = cfg_words;
               word_cnt_d  = '0;
               load_cnt_d  = '0;
               tag_idx_d   = '0;
`ifdef MCAST_TAG_SENDER_BCAST_EN
               bcast_d     = cfg_bcast;
`endif
               state_d     = (cfg_words == 16'd0) ? ST_FIN : ST_RUN;
            end
         end

         ST_RUN: begin
            if (load) begin
               out_valid_d = 1'b1;
               out_val_d   = fifo_head;
               out_tag_d   = cur_tag;
               tag_idx_d   = last_idx ? '0 : tag_idx_q + (ID_WIDTH + 1)'(1);
`ifdef MCAST_TAG_SENDER_BCAST_EN
               out_last_d  = !bcast_q || last_idx;
`endif
               if (word_loaded) begin
                  load_cnt_d = load_cnt_q + 16'd1;
               end
            end else if (transfer) begin
               out_valid_d = 1'b0;
            end

            if (transfer && beat_last) begin
               word_cnt_d = word_cnt_q + 16'd1;
            end
            if (final_beat) begin
               state_d = ST_FIN;
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         start_tag_q <= '0;
         win_q       <= (ID_WIDTH + 1)'(1);
         words_q     <= '0;
         word_cnt_q  <= '0;
         load_cnt_q  <= '0;
         tag_idx_q   <= '0;
         out_val_q   <= '0;
         out_tag_q   <= '0;
         out_valid_q <= 1'b0;
`ifdef MCAST_TAG_SENDER_BCAST_EN
         bcast_q     <= 1'b0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         start_tag_q <= start_tag_d;
         win_q       <= win_d;
         words_q     <= words_d;
         word_cnt_q  <= word_cnt_d;
         load_cnt_q  <= load_cnt_d;
         tag_idx_q   <= tag_idx_d;
         out_val_q   <= out_val_d;
         out_tag_q   <= out_tag_d;
         out_valid_q <= out_valid_d;
`ifdef MCAST_TAG_SENDER_BCAST_EN
         bcast_q     <= bcast_d;
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign bus.out_val   = out_val_q;
   assign bus.out_tag   = out_tag_q;
   assign bus.out_valid = out_valid_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_FIN);

endmodule

// File: tb/tb_mcast_tag_sender.sv
// -----------------------------------------------------------------------------
// tb_mcast_tag_sender
//
// Purpose: self-checking bench for mcast_tag_sender. Expected (value, tag)
//    beats are pushed into a scoreboard when a pass is configured; observed
//    beats are collected on the falling edge and popped against it.
// -----------------------------------------------------------------------------
module tb_mcast_tag_sender;

   localparam int DW   = 16;
   localparam int IW   = 4;
   localparam int NIDS = 14;
   localparam int FD   = 4;

`ifdef MCAST_TAG_SENDER_BCAST_EN
   localparam bit BCAST_ON = 1'b1;
`else
   localparam bit BCAST_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cfg_start = 1'b0;
   logic [IW-1:0] cfg_start_tag = '0;
   logic [IW:0]   cfg_num_tags = '0;
   logic [15:0]   cfg_words = '0;
   logic          cfg_bcast = 1'b0;
   logic          busy;
   logic          done;

   mcast_tag_sender_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   mcast_tag_sender #(
      .DATA_WIDTH (DW),
      .ID_WIDTH   (IW),
      .NUM_IDS    (NIDS),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .cfg_start     (cfg_start),
      .cfg_start_tag (cfg_start_tag),
      .cfg_num_tags  (cfg_num_tags),
      .cfg_words     (cfg_words),
      .cfg_bcast     (cfg_bcast),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [DW-1:0] exp_val [$];
   logic [IW-1:0] exp_tag [$];
   logic [DW-1:0] obs_val [$];
   logic [IW-1:0] obs_tag [$];
   int            obs_cyc [$];
   int            done_cyc [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Falling-edge monitor: a beat seen valid&ready here transfers on the next rise.
   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) begin
         obs_val.push_back(bus.out_val);
         obs_tag.push_back(bus.out_tag);
         obs_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1);
   end

   // ------------------------------------------------------------ helpers --
   task automatic clear_sb();
      exp_val.delete(); exp_tag.delete();
      obs_val.delete(); obs_tag.delete(); obs_cyc.delete();
      done_cyc.delete();
   endtask

   // Reference model: the beats a pass should produce.
   task automatic model_pass(input logic [IW-1:0] st, input logic [IW:0] num, input int words,
                             input bit bc, input logic [DW-1:0] base, input logic [DW-1:0] step);
      int            win;
      logic [DW-1:0] d;
      win = (num == 0) ? 1 : ((int'(num) > NIDS) ? NIDS : int'(num));
      for (int w = 0; w < words; w++) begin
         d = base + DW'(w) * step;
         if (bc && BCAST_ON) begin
            for (int r = 0; r < win; r++) begin
               exp_val.push_back(d);
               exp_tag.push_back(IW'((int'(st) + r) % NIDS));
            end
         end else begin
            exp_val.push_back(d);
            exp_tag.push_back(IW'((int'(st) + (w % win)) % NIDS));
         end
      end
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.in_ready) break;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic start_pass(input logic [IW-1:0] st, input logic [IW:0] num,
                             input logic [15:0] words, input bit bc);
      cfg_start_tag = st;
      cfg_num_tags  = num;
      cfg_words     = words;
      cfg_bcast     = bc;
      cfg_start     = 1'b1;
      @(posedge clk); #1;
      cfg_start     = 1'b0;
   endtask

   // Models the pass, pushes words pre..npush-1 and starts the pass in parallel.
   task automatic do_pass(input logic [IW-1:0] st, input logic [IW:0] num, input int words,
                          input bit bc, input int npush, input int pre,
                          input logic [DW-1:0] base, input logic [DW-1:0] step);
      model_pass(st, num, words, bc, base, step);
      fork
         begin
            for (int i = pre; i < npush; i++) push_word(base + DW'(i) * step);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            start_pass(st, num, 16'(words), bc);
         end
      join
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (done_cyc.size() > 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (done_cyc.size() > 0) ok = 1'b1;
      @(posedge clk); #1;
   endtask

   // -------------------------------------------------------------- tests --
   task automatic test_reset();
      rst = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
      cfg_start = 1'b1; cfg_words = 16'd3; cfg_num_tags = 5'd2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.out_val !== '0) $display("FAIL reset_out_val: got %h required 0000", bus.out_val);
      else n_pass++;
      n_checks++;
      if (bus.out_tag !== '0) $display("FAIL reset_out_tag: got %0d required 0", bus.out_tag);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got busy=%b done=%b required 0 0", busy, done);
      else n_pass++;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; cfg_start = 1'b0; rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release: got in_ready=%b busy=%b required 1 0", bus.in_ready, busy);
      else n_pass++;
      $display("reset: outputs cleared, in_ready=%b after release", bus.in_ready);

      // Abort a pass that is stalled mid-RUN.
      @(posedge clk); #1;
      clear_sb();
      bus.out_ready = 1'b0;
      push_word(16'h0101);
      push_word(16'h0202);
      start_pass(4'd0, 5'd2, 16'd5, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || busy !== 1'b1) $display("FAIL midrun_active: got out_valid=%b busy=%b required 1 1", bus.out_valid, busy);
      else n_pass++;
      #3 rst = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL midrun_reset: got out_valid=%b busy=%b done=%b required 0 0 0", bus.out_valid, busy, done);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b1;
      bus.out_ready = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++;
      if (done_cyc.size() != 0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL midrun_after: got done_pulses=%0d out_valid=%b in_ready=%b required 0 0 1", done_cyc.size(), bus.out_valid, bus.in_ready);
      else n_pass++;
      $display("reset mid-run: pass aborted, done pulses=%0d", done_cyc.size());
      @(posedge clk); #1;
      clear_sb();
   endtask

   task automatic test_basic();
      bit            ok;
      int            i, c0, last;
      logic [DW-1:0] ev, ov;
      logic [IW-1:0] et, ot;
      int            oc;
      clear_sb();
      bus.out_ready = 1'b1;
      do_pass(4'd0, 5'd3, 6, 1'b0, 6, 0, 16'h0011, 16'h0001);
      wait_done(200, ok);
      n_checks++;
      if (!ok) $display("FAIL basic_done_timeout: got no done pulse required one within 200 cycles");
      else n_pass++;
      i = 0; c0 = 0; last = 0;
      while (exp_val.size() > 0 && obs_val.size() > 0) begin
         ev = exp_val.pop_front(); et = exp_tag.pop_front();
         ov = obs_val.pop_front(); ot = obs_tag.pop_front(); oc = obs_cyc.pop_front();
         if (i == 0) c0 = oc;
         n_checks++;
         if (ov !== ev || ot !== et || oc != c0 + i)
            $display("FAIL basic_beat%0d: got val=%h tag=%0d cyc=%0d required val=%h tag=%0d cyc=%0d", i, ov, ot, oc, ev, et, c0 + i);
         else begin
            n_pass++;
            $display("basic beat %0d: val=%h tag=%0d", i, ov, ot);
         end
         last = oc;
         i++;
      end
      n_checks++;
      if (exp_val.size() != 0 || obs_val.size() != 0)
         $display("FAIL basic_count: got %0d extra observed, %0d missing required 0 0", obs_val.size(), exp_val.size());
      else n_pass++;
      n_checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != last + 1)
         $display("FAIL basic_done_timing: got pulses=%0d first_cyc=%0d required 1 at %0d",
                  done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, last + 1);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL basic_busy_fall: got %b required 0", busy);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      logic [IW-1:0] st_tab  [3];
      logic [IW:0]   num_tab [3];
      int            wd_tab  [3];
      bit            ok;
      int            i;
      logic [DW-1:0] ev, ov;
      logic [IW-1:0] et, ot;
      st_tab  = '{4'd12, 4'd5, 4'd3};
      num_tab = '{5'd4, 5'd0, 5'd20};
      wd_tab  = '{4, 3, 16};
      for (int p = 0; p < 3; p++) begin
         clear_sb();
         do_pass(st_tab[p], num_tab[p], wd_tab[p], 1'b0, wd_tab[p], 0, DW'(16'h0100 * (p + 2)), 16'h0001);
         wait_done(300, ok);
         n_checks++;
         if (!ok) $display("FAIL wrap%0d_done_timeout: got no done required one", p);
         else n_pass++;
         i = 0;
         while (exp_val.size() > 0 && obs_val.size() > 0) begin
            ev = exp_val.pop_front(); et = exp_tag.pop_front();
            ov = obs_val.pop_front(); ot = obs_tag.pop_front(); void'(obs_cyc.pop_front());
            n_checks++;
            if (ov !== ev || ot !== et)
               $display("FAIL wrap%0d_beat%0d: got val=%h tag=%0d required val=%h tag=%0d", p, i, ov, ot, ev, et);
            else begin
               n_pass++;
               $display("wrap pass %0d beat %0d: val=%h tag=%0d", p, i, ov, ot);
            end
            i++;
         end
         n_checks++;
         if (exp_val.size() != 0 || obs_val.size() != 0)
            $display("FAIL wrap%0d_count: got %0d extra, %0d missing required 0 0", p, obs_val.size(), exp_val.size());
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      bit            ok;
      bit            stop;
      bit            prev_stall;
      logic [DW-1:0] pv, ev, ov;
      logic [IW-1:0] pt, et, ot;
      bit            pat [4];
      int            i;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      clear_sb();
      stop = 1'b0; prev_stall = 1'b0; pv = '0; pt = '0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < FD; k++) push_word(16'h0400 + DW'(k));
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL stall_fifo_full: got in_ready=%b required 0", bus.in_ready);
      else n_pass++;
      $display("stall: FIFO filled to %0d, in_ready=%b", FD, bus.in_ready);
      @(posedge clk); #1;
      fork
         begin
            do_pass(4'd2, 5'd5, 6, 1'b0, 6, FD, 16'h0400, 16'h0001);
            wait_done(400, ok);
            stop = 1'b1;
         end
         begin
            for (int k = 0; k < 600 && !stop; k++) begin
               bus.out_ready = pat[k % 4];
               @(posedge clk); #1;
            end
         end
         begin
            for (int k = 0; k < 600 && !stop; k++) begin
               @(negedge clk);
               if (prev_stall) begin
                  n_checks++;
                  if (bus.out_valid !== 1'b1 || bus.out_val !== pv || bus.out_tag !== pt)
                     $display("FAIL stall_hold: got valid=%b val=%h tag=%0d required 1 %h %0d", bus.out_valid, bus.out_val, bus.out_tag, pv, pt);
                  else n_pass++;
               end
               prev_stall = bus.out_valid && !bus.out_ready;
               pv = bus.out_val;
               pt = bus.out_tag;
            end
         end
      join
      bus.out_ready = 1'b1;
      n_checks++;
      if (!ok) $display("FAIL stall_done_timeout: got no done required one");
      else n_pass++;
      i = 0;
      while (exp_val.size() > 0 && obs_val.size() > 0) begin
         ev = exp_val.pop_front(); et = exp_tag.pop_front();
         ov = obs_val.pop_front(); ot = obs_tag.pop_front(); void'(obs_cyc.pop_front());
         n_checks++;
         if (ov !== ev || ot !== et)
            $display("FAIL stall_beat%0d: got val=%h tag=%0d required val=%h tag=%0d", i, ov, ot, ev, et);
         else begin
            n_pass++;
            $display("stall beat %0d: val=%h tag=%0d", i, ov, ot);
         end
         i++;
      end
      n_checks++;
      if (exp_val.size() != 0 || obs_val.size() != 0)
         $display("FAIL stall_count: got %0d extra, %0d missing required 0 0", obs_val.size(), exp_val.size());
      else n_pass++;
   endtask

   task automatic test_zero_and_ignore();
      bit            ok;
      int            i;
      logic [DW-1:0] ev, ov;
      logic [IW-1:0] et, ot;
      clear_sb();
      bus.out_ready = 1'b1;
      start_pass(4'd0, 5'd3, 16'd0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL zero_done: got done=%b out_valid=%b required 1 0", done, bus.out_valid);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_after: got done=%b busy=%b required 0 0", done, busy);
      else n_pass++;
      $display("zero-word pass: done pulses=%0d beats=%0d", done_cyc.size(), obs_val.size());
      @(posedge clk); #1;

      clear_sb();
      model_pass(4'd1, 5'd2, 3, 1'b0, 16'h0500, 16'h0001);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) push_word(16'h0500 + DW'(k));
      start_pass(4'd1, 5'd2, 16'd3, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      start_pass(4'd7, 5'd1, 16'd1, 1'b0);
      bus.out_ready = 1'b1;
      wait_done(200, ok);
      n_checks++;
      if (!ok) $display("FAIL ignore_done_timeout: got no done required one");
      else n_pass++;
      i = 0;
      while (exp_val.size() > 0 && obs_val.size() > 0) begin
         ev = exp_val.pop_front(); et = exp_tag.pop_front();
         ov = obs_val.pop_front(); ot = obs_tag.pop_front(); void'(obs_cyc.pop_front());
         n_checks++;
         if (ov !== ev || ot !== et)
            $display("FAIL ignore_beat%0d: got val=%h tag=%0d required val=%h tag=%0d", i, ov, ot, ev, et);
         else begin
            n_pass++;
            $display("ignore beat %0d: val=%h tag=%0d", i, ov, ot);
         end
         i++;
      end
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_val.size() != 0 || obs_val.size() != 0 || done_cyc.size() != 1 || busy !== 1'b0)
         $display("FAIL ignore_count: got extra=%0d missing=%0d done_pulses=%0d busy=%b required 0 0 1 0",
                  obs_val.size(), exp_val.size(), done_cyc.size(), busy);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_bcast();
      bit            ok;
      int            i;
      logic [DW-1:0] ev, ov;
      logic [IW-1:0] et, ot;
      clear_sb();
      bus.out_ready = 1'b1;
      do_pass(4'd5, 5'd3, 2, 1'b1, 2, 0, 16'hAAAA, 16'h1111);
      wait_done(200, ok);
      n_checks++;
      if (!ok) $display("FAIL bcast_done_timeout: got no done required one");
      else n_pass++;
      i = 0;
      while (exp_val.size() > 0 && obs_val.size() > 0) begin
         ev = exp_val.pop_front(); et = exp_tag.pop_front();
         ov = obs_val.pop_front(); ot = obs_tag.pop_front(); void'(obs_cyc.pop_front());
         n_checks++;
         if (ov !== ev || ot !== et)
            $display("FAIL bcast_beat%0d: got val=%h tag=%0d required val=%h tag=%0d", i, ov, ot, ev, et);
         else begin
            n_pass++;
            $display("bcast beat %0d: val=%h tag=%0d", i, ov, ot);
         end
         i++;
      end
      n_checks++;
      if (exp_val.size() != 0 || obs_val.size() != 0 || done_cyc.size() != 1)
         $display("FAIL bcast_count: got extra=%0d missing=%0d done_pulses=%0d required 0 0 1",
                  obs_val.size(), exp_val.size(), done_cyc.size());
      else n_pass++;
   endtask

   initial begin
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_zero_and_ignore();
      test_bcast();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
